array_stream_port: RTL

//  Memory-side stage for stream compute functions that take an Array argument.

---
 rtl/array_stream_port_pkg.sv | 18 +
 rtl/array_stream_port_if.sv | 41 ++++
 rtl/array_stream_port_spram.sv | 38 +++
 rtl/array_stream_port.sv | 104 ++++++++++
 4 files changed

// File: rtl/array_stream_port_pkg.sv
// Shared types and constants for the array stream port: address/data widths,
// the "not yet written" marker bit and the arbiter's last-grant encoding.
package array_stream_port_pkg;

  localparam int ADDR_N      = 9;
  localparam int INT_N       = 32;
  localparam int INVALID_BIT = 31;

  typedef enum logic {
    GR_READ  = 1'b0,
    GR_WRITE = 1'b1
  } grant_e;

  function automatic logic xfer(input logic valid, input logic ready);
    return valid && ready;
  endfunction

endpackage

// File: rtl/array_stream_port_if.sv
// Stream bundle of the array port: read-address in, write-address/data in,
// read-data out and the null write-ack stream out.
interface array_stream_port_if
  import array_stream_port_pkg::*;
#(
  parameter int AW = ADDR_N,
  parameter int DW = INT_N
);

  logic [AW-1:0] rd_addr;
  logic          rd_addr_valid;
  logic          rd_addr_ready;
  logic [AW-1:0] wr_addr;
  logic          wr_addr_valid;
  logic          wr_addr_ready;
  logic [DW-1:0] wr_data;
  logic          wr_data_valid;
  logic          wr_data_ready;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          rd_data_ready;
  logic          wr_ack_valid;
  logic          wr_ack_ready;

  modport master (
    output rd_addr, rd_addr_valid, input rd_addr_ready,
    output wr_addr, wr_addr_valid, input wr_addr_ready,
    output wr_data, wr_data_valid, input wr_data_ready,
    input  rd_data, rd_data_valid, output rd_data_ready,
    input  wr_ack_valid, output wr_ack_ready
  );

  modport slave (
    input  rd_addr, rd_addr_valid, output rd_addr_ready,
    input  wr_addr, wr_addr_valid, output wr_addr_ready,
    input  wr_data, wr_data_valid, output wr_data_ready,
    output rd_data, rd_data_valid, input rd_data_ready,
    output wr_ack_valid, input wr_ack_ready
  );

endinterface

// File: rtl/array_stream_port_spram.sv
// Synchronous single-port RAM, preloaded with INIT at configuration, one-cycle
// read latency. Addresses at or beyond N never write and read back as INIT.
module array_stream_port_spram
  import array_stream_port_pkg::*;
#(
  parameter int            N    = 512,
  parameter int            AW   = ADDR_N,
  parameter int            DW   = INT_N,
  parameter logic [DW-1:0] INIT = DW'(1) << INVALID_BIT
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [DW-1:0] mem [N] = '{default: INIT};
  logic [IW-1:0] idx;
  logic          in_range;

  assign idx      = addr[IW-1:0];
  assign in_range = 32'(addr) < N;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        if (in_range) mem[idx] <= wdata;
      end else begin
        rdata <= in_range ? mem[idx] : INIT;
      end
    end
  end

endmodule

// File: rtl/array_stream_port.sv
// Memory-side stage for array-argument compute functions: fairly interleaves a
// read stream and a write stream onto one RAM port, returns read data and write acks.
module array_stream_port
  import array_stream_port_pkg::*;
#(
  parameter int            N    = 512,
  parameter int            AW   = ADDR_N,
  parameter int            DW   = INT_N,
  parameter logic [DW-1:0] INIT = DW'(1) << INVALID_BIT
) (
  input  logic               clk,
  input  logic               nrst,
  array_stream_port_if.slave bus
);

  grant_e        last_grant;
  logic          rd_vld_p1;
  logic [1:0]    fifo_cnt;
  logic          fifo_wptr;
  logic          fifo_rptr;
  logic [DW-1:0] fifo_mem [2];
  logic          ack_vld;

  logic          pop;
  logic          push;
  logic [2:0]    occ;
  logic          rd_elig;
  logic          wr_elig;
  logic          gr_rd;
  logic          gr_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_q;

  // Occupancy counts the read already in the RAM pipe, so a full FIFO can still
  // accept a new read in the same cycle it is popped.
  assign pop     = xfer(bus.rd_data_valid, bus.rd_data_ready);
  assign push    = rd_vld_p1;
  assign occ     = 3'(fifo_cnt) + 3'(rd_vld_p1) - 3'(pop);
  assign rd_elig = bus.rd_addr_valid && (occ < 3'd2);
  assign wr_elig = bus.wr_addr_valid && bus.wr_data_valid && (!ack_vld || bus.wr_ack_ready);

  always_comb begin
    gr_rd = 1'b0;
    gr_wr = 1'b0;
    if (rd_elig && wr_elig) begin
      gr_wr = (last_grant == GR_READ);
      gr_rd = (last_grant == GR_WRITE);
    end else begin
      gr_rd = rd_elig;
      gr_wr = wr_elig;
    end
  end

  assign bus.rd_addr_ready = gr_rd;
  assign bus.wr_addr_ready = gr_wr;
  assign bus.wr_data_ready = gr_wr;
  assign bus.rd_data_valid = (fifo_cnt != 2'd0);
  assign bus.rd_data       = fifo_mem[fifo_rptr];
  assign bus.wr_ack_valid  = ack_vld;
  assign ram_addr          = gr_wr ? bus.wr_addr : bus.rd_addr;

  array_stream_port_spram #(
    .N    (N),
    .AW   (AW),
    .DW   (DW),
    .INIT (INIT)
  ) u_ram (
    .clk   (clk),
    .en    (gr_rd || gr_wr),
    .we    (gr_wr),
    .addr  (ram_addr),
    .wdata (bus.wr_data),
    .rdata (ram_q)
  );

  // p0 -> p1: grant issued to RAM; read data lands in the FIFO one cycle later
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      last_grant <= GR_READ;
      rd_vld_p1  <= 1'b0;
      fifo_cnt   <= 2'd0;
      fifo_wptr  <= 1'b0;
      fifo_rptr  <= 1'b0;
      ack_vld    <= 1'b0;
    end else begin
      if (rd_elig && wr_elig) last_grant <= gr_wr ? GR_WRITE : GR_READ;
      rd_vld_p1 <= gr_rd;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: ;
      endcase
      if (push) fifo_wptr <= ~fifo_wptr;
      if (pop)  fifo_rptr <= ~fifo_rptr;
      if (gr_wr)                 ack_vld <= 1'b1;
      else if (bus.wr_ack_ready) ack_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wptr] <= ram_q;
  end

endmodule
